// File: rtl/sat.sv
// Registered signed saturator: clamps an isz-bit sample into osz bits with a
// one-cycle latency and clip flags. Define SAT_SYMMETRIC_EN for a symmetric range.
module sat #(
  parameter int isz = 11,
  parameter int osz = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [isz-1:0] in,
  input  logic                  in_valid,
  input  logic                  ovf_clr,
  output logic signed [osz-1:0] out,
  output logic                  out_valid,
  output logic                  ovf,
  output logic                  ovf_sticky
);

  localparam logic [osz-1:0] MAX_VAL = {1'b0, {(osz-1){1'b1}}};
  localparam logic [osz-1:0] NEG_FULL = ~MAX_VAL;

`ifdef SAT_SYMMETRIC_EN
  localparam logic [osz-1:0] MIN_VAL = NEG_FULL + osz'(1);
`else
  localparam logic [osz-1:0] MIN_VAL = NEG_FULL;
`endif

  logic [isz-osz:0] top_bits;
  logic             out_of_range;
  logic             clip;
  logic [osz-1:0]   sat_val;

  // The sample fits in osz bits exactly when every bit from the output sign
  // bit upward is a copy of the input sign bit.
  assign top_bits     = in[isz-1:osz-1];
  assign out_of_range = !((&top_bits) || !(|top_bits));

  // NOTE: every signal written here gets a default first, so no latch can be
  // inferred on any path through the if/else chain.
  always_comb begin
    clip    = 1'b0;
    sat_val = in[osz-1:0];
    if (out_of_range) begin
      clip    = 1'b1;
      sat_val = in[isz-1] ? MIN_VAL : MAX_VAL;
    end
`ifdef SAT_SYMMETRIC_EN
    else if (in[osz-1:0] == NEG_FULL) begin
      clip    = 1'b1;
      sat_val = MIN_VAL;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out        <= '0;
      out_valid  <= 1'b0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= sat_val;
        ovf <= clip;
      end
      // A clip registered on the same edge as a clear keeps the flag set.
      if (in_valid && clip) begin
        ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sat.sv
// Directed bench for sat (isz=11, osz=10); honours SAT_SYMMETRIC_EN for the
// expected negative limit.
module tb_sat;

  localparam int ISZ = 11;
  localparam int OSZ = 10;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic signed [ISZ-1:0] din;
  logic                  din_valid;
  logic                  clr;
  logic signed [OSZ-1:0] dout;
  logic                  dout_valid;
  logic                  ovf;
  logic                  ovf_sticky;

  int checks = 0;
  int errors = 0;

  sat #(.isz(ISZ), .osz(OSZ)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .in        (din),
    .in_valid  (din_valid),
    .ovf_clr   (clr),
    .out       (dout),
    .out_valid (dout_valid),
    .ovf       (ovf),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then settle just after the
  // following rising edge so the registered result can be read.
  task automatic step(input int v, input logic vld, input logic c);
    @(negedge clk);
    din       = ISZ'(v);
    din_valid = vld;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  function automatic int lim_max();
    return (1 << (OSZ - 1)) - 1;
  endfunction

  function automatic int lim_min();
`ifdef SAT_SYMMETRIC_EN
    return -lim_max();
`else
    return -lim_max() - 1;
`endif
  endfunction

  function automatic int model_out(input int v);
    if (v > lim_max()) return lim_max();
    if (v < lim_min()) return lim_min();
    return v;
  endfunction

  function automatic logic model_ovf(input int v);
    return (v > lim_max()) || (v < lim_min());
  endfunction

  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    clr       = 1'b0;

    // Reset state, with a valid sample presented that must be ignored.
    din       = ISZ'(600);
    din_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_sticky", ovf_sticky, 0);

    @(negedge clk);
    din_valid = 1'b0;
    rst_n     = 1'b1;

    // Positive clip right after reset release.
    step(600, 1'b1, 1'b0);
    check("p600_out", dout, 511);
    check("p600_ovf", ovf, 1);
    check("p600_valid", dout_valid, 1);
    check("p600_sticky", ovf_sticky, 1);

    step(-700, 1'b1, 1'b0);
    check("m700_out", dout, -512 + ((lim_min() == -511) ? 1 : 0));
    check("m700_ovf", ovf, 1);

    step(-512, 1'b1, 1'b0);
`ifdef SAT_SYMMETRIC_EN
    check("m512_out", dout, -511);
    check("m512_ovf", ovf, 1);
`else
    check("m512_out", dout, -512);
    check("m512_ovf", ovf, 0);
`endif

    step(-511, 1'b1, 1'b0);
    check("m511_out", dout, -511);
    check("m511_ovf", ovf, 0);

    step(511, 1'b1, 1'b0);
    check("p511_out", dout, 511);
    check("p511_ovf", ovf, 0);
    check("p511_valid", dout_valid, 1);

    // Idle cycle after a clip: out and ovf hold, out_valid drops.
    step(600, 1'b1, 1'b0);
    step(-3, 1'b0, 1'b0);
    check("idle_valid", dout_valid, 0);
    check("idle_out_hold", dout, 511);
    check("idle_ovf_hold", ovf, 1);

    // Clear, then clip / pass / clear sequence.
    step(0, 1'b0, 1'b1);
    check("clr0_sticky", ovf_sticky, 0);
    step(600, 1'b1, 1'b0);
    check("seq600_ovf", ovf, 1);
    check("seq600_sticky", ovf_sticky, 1);
    step(5, 1'b1, 1'b0);
    check("seq5_out", dout, 5);
    check("seq5_ovf", ovf, 0);
    check("seq5_sticky", ovf_sticky, 1);
    step(0, 1'b0, 1'b1);
    check("seqclr_sticky", ovf_sticky, 0);
    step(1023, 1'b1, 1'b1);
    check("setwins_out", dout, 511);
    check("setwins_ovf", ovf, 1);
    check("setwins_sticky", ovf_sticky, 1);
    step(7, 1'b1, 1'b1);
    check("clrpass_sticky", ovf_sticky, 0);
    check("clrpass_out", dout, 7);

    // Asynchronous reset between edges with a sample in flight.
    step(600, 1'b1, 1'b0);
    @(negedge clk);
    din       = ISZ'(-700);
    din_valid = 1'b1;
    clr       = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_out", dout, 0);
    check("async_valid", dout_valid, 0);
    check("async_ovf", ovf, 0);
    check("async_sticky", ovf_sticky, 0);
    din_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", dout_valid, 0);
    check("post_rst_out", dout, 0);
    step(0, 1'b0, 1'b0);
    check("post_rst_valid2", dout_valid, 0);

    // Back-to-back sweep of all input codes in a scrambled order.
    for (int i = 0; i < (1 << ISZ); i++) begin
      int code;
      int v;
      code = (i * 1237 + 91) % (1 << ISZ);
      v    = (code >= (1 << (ISZ - 1))) ? code - (1 << ISZ) : code;
      step(v, 1'b1, 1'b0);
      check($sformatf("sweep_out_%0d", v), dout, model_out(v));
      check($sformatf("sweep_ovf_%0d", v), ovf, model_ovf(v));
      check($sformatf("sweep_valid_%0d", v), dout_valid, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sat.md
SAT -- requirements
Module: sat

Interface
REQ-001 Parameter isz, default 11: input word width in bits, signed two's complement; isz >= 2.
REQ-002 Parameter osz, default 10: output word width in bits, signed two's complement; 2 <= osz <= isz.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is asynchronous and active-low (asserted at 0).
REQ-005 Port in, input, isz bits, signed: sample to be saturated.
REQ-006 Port in_valid, input, 1 bit: qualifies in for the current cycle.
REQ-007 Port ovf_clr, input, 1 bit: synchronous clear of ovf_sticky.
REQ-008 Port out, output, osz bits, signed, registered: saturated sample.
REQ-009 Port out_valid, output, 1 bit, registered: out holds a new sample this cycle.
REQ-010 Port ovf, output, 1 bit, registered: the sample on out was clipped.
REQ-011 Port ovf_sticky, output, 1 bit, registered: at least one clip since the last clear or reset.

Function
REQ-012 Define MAX = 2^(osz-1)-1 and MIN = -2^(osz-1), both exact integers at width osz.
REQ-013 Clamp rule, per qualified sample:
  - in > MAX: out = MAX, ovf = 1.
  - in < MIN: out = MIN, ovf = 1.
  - otherwise: out = in[osz-1:0] (value preserved), ovf = 0.
REQ-014 Detect out-of-range by checking that bits in[isz-1:osz-1] are not all equal; in[isz-1] selects the clip direction.
REQ-015 If isz == osz: out = in and ovf is never set.
REQ-016 Latency is exactly 1 clk cycle from a sample accepted with in_valid=1 to out, ovf and out_valid=1.
REQ-017 When in_valid=0 in a cycle:
  - out_valid = 0 on the next edge;
  - out and ovf hold their previous values.
REQ-018 Back-to-back samples are accepted every cycle with no throughput loss or stall.
REQ-019 ovf_sticky sets on any edge where a clipped sample is registered (same edge that sets ovf).
REQ-020 ovf_clr=1 clears ovf_sticky on the next edge; if a clip is registered on that same edge, set wins and ovf_sticky = 1.
REQ-021 The block contains no other state beyond REQ-012..REQ-020; there is no handshake back-pressure.

Reset
REQ-022 While reset=0, asynchronously and independent of clk: out = 0, out_valid = 0, ovf = 0, ovf_sticky = 0.
REQ-023 Reset deassertion: the first sample is accepted on the first rising clk edge with reset=1.
REQ-024 Reset asserted mid-stream discards the in-flight sample; it does not appear on out.

Configuration
REQ-025 Macro SAT_SYMMETRIC_EN:
  - When defined: MIN = -(2^(osz-1)-1), giving a symmetric range. Input equal to -2^(osz-1) is clipped to MIN with ovf = 1.
  - When undefined: MIN = -2^(osz-1) as in REQ-012.
  - MAX, latency and flag behaviour are identical in both builds.

Verification (isz=11, osz=10, macro undefined unless stated)
REQ-026 in = 600 with in_valid=1 -> one cycle later out = 511, ovf = 1, out_valid = 1, ovf_sticky = 1.
REQ-027 in = -700 -> out = -512, ovf = 1; in = -512 -> out = -512, ovf = 0; in = 511 -> out = 511, ovf = 0.
REQ-028 SAT_SYMMETRIC_EN defined: in = -512 -> out = -511, ovf = 1; in = -511 -> out = -511, ovf = 0.
REQ-029 Sequence 600, 5, then ovf_clr=1 for one cycle:
  - ovf reads 1, 0 over the two samples while ovf_sticky stays 1;
  - ovf_sticky = 0 after the clear;
  - ovf_clr asserted together with in = 1023 -> ovf_sticky stays 1.
REQ-030 Pulse reset=0 mid-stream between clock edges -> all outputs read 0 immediately; with in_valid held at 0, out_valid stays 0 after release.
REQ-031 Random sweep of all 2048 input codes, back-to-back -> every out matches the clamp reference model at 1-cycle latency.
